branch_unit: RTL and testbench
==============================

// Module: branch_unit
// PURPOSE
//  Control-flow end of the program-counter interface: watches the byte fetched at the current PC
//  address and drives load_addr/target_addr back into the program counter.
//  Decodes JMP/JZ/JNZ/JC/CALL/RET and holds a return-address stack for CALL/RET.
//  Tracks opcode vs operand bytes so operands are never decoded as opcodes.
//  Sits between program ROM output and the PC; the main decoder handles all non-branch opcodes.
// PARAMETERS
//  STACK_DEPTH  4  return-address entries (power of 2, 2..16)
// PORTS
//  clk          in   1  clock; all state updates on posedge clk
//  rst          in   1  reset, synchronous, active-high
//  pc_addr      in   8  current PC address (the address of instr_data)
//  instr_data   in   8  program byte at pc_addr, valid every cycle
//  other_arg    in   1  main decoder: current non-branch opcode carries one operand byte
//  flag_z       in   1  ALU zero flag
//  flag_c       in   1  ALU carry flag
//  load_addr    out  1  PC load request (combinational, stable before negedge clk)
//  target_addr  out  8  PC load address (combinational)
//  in_operand   out  1  current byte is an operand (state == ARG)
//  stack_count  out  clog2(STACK_DEPTH)+1  valid stack entries
//  stack_err    out  1  sticky: overflow or underflow since reset
// BEHAVIOUR
//  Opcodes: F0 JMP a, F1 JZ a, F2 JNZ a, F3 JC a, F4 CALL a (2 bytes each, a = operand byte);
//   F5 RET (1 byte). Any other byte is non-branch: 2 bytes if other_arg=1, else 1 byte.
//  States: OP (byte is an opcode), ARG (byte is an operand). Reset -> OP.
//  OP: F0..F4 -> latch opcode into op_r, go ARG; non-branch with other_arg=1 -> op_r=00, go ARG;
//   F5 -> load_addr=1, target_addr=stack top, pop on posedge, stay OP; other -> stay OP.
//  ARG: condition taken = JMP | CALL | (JZ & flag_z) | (JNZ & ~flag_z) | (JC & flag_c), using
//   op_r and flags sampled in the same cycle. Taken -> load_addr=1, target_addr=instr_data.
//   CALL additionally pushes pc_addr+1 (8-bit wrap, FF+1=00) on posedge. Always -> OP.
//  Not taken / non-branch: load_addr=0, target_addr=8'h00.
//  Latency: load is requested in the same cycle as the deciding byte; the PC presents the target
//   on the next posedge, so the byte after a jump is always decoded in OP. No bubble cycles.
//  Stack: array + pointer, push writes [sp] then sp+1; pop reads [sp-1] then sp-1.
//   Push when stack_count==STACK_DEPTH: overwrite oldest (circular), count stays full,
//   stack_err<=1. Pop when count==0: target_addr=8'h00, load still asserted, count stays 0,
//   stack_err<=1.
//  stack_err cleared only by rst.
//  rst=1: load_addr=0 and target_addr=00 combinationally; on posedge state=OP, op_r=00,
//   stack_count=0, stack_err=0. Stack contents are don't-care.
//   Reset during ARG discards the pending operand.
//  Reset values: load_addr=0, target_addr=00, in_operand=0, stack_count=0, stack_err=0.
// TESTING
//  1 JMP: bytes @00: F0 20 -> cycle@01 load_addr=1 target=20; next pc_addr=20, state OP.
//  2 JZ/JNZ: F1 40 with flag_z=0 -> no load, PC continues 02; F2 40 flag_z=0 -> load 40.
//  3 CALL/RET: @10: F4 80; @80: F5 -> push 12, load 80; RET loads 12, stack_count 1->0.
//  4 Operand masking: other_arg=1 opcode 3A, operand F5 -> no load (F5 treated as data).
//  5 Overflow/underflow: 5 nested CALLs (DEPTH=4) -> stack_err=1, count=4; RET from empty
//    -> target 00.
//  6 Reset mid-ARG: rst during operand cycle of F0 -> load_addr=0, next byte decoded as OP.

Source files
------------

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch decode and return-address stack driving the PC load port
// Tracks opcode/operand bytes, resolves JMP/JZ/JNZ/JC/CALL/RET, and keeps a circular return stack.
module branch_unit #(
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     pc_addr,
  input  logic [7:0]                     instr_data,
  input  logic                           other_arg,
  input  logic                           flag_z,
  input  logic                           flag_c,
  output logic                           load_addr,
  output logic [7:0]                     target_addr,
  output logic                           in_operand,
  output logic [$clog2(STACK_DEPTH):0]   stack_count,
  output logic                           stack_err
);

  localparam int SPW = $clog2(STACK_DEPTH);
  localparam int CW  = SPW + 1;
  localparam logic [SPW-1:0] SP_ONE    = SPW'(1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]  CNT_FULL  = CW'(STACK_DEPTH);

  localparam logic [7:0] OP_JMP  = 8'hF0;
  localparam logic [7:0] OP_JZ   = 8'hF1;
  localparam logic [7:0] OP_JNZ  = 8'hF2;
  localparam logic [7:0] OP_JC   = 8'hF3;
  localparam logic [7:0] OP_CALL = 8'hF4;
  localparam logic [7:0] OP_RET  = 8'hF5;

  typedef enum logic {ST_OP, ST_ARG} state_t;

  state_t          state_q, state_d;
  logic [7:0]      op_q, op_d;
  logic [SPW-1:0]  sp_q;
  logic [CW-1:0]   count_q;
  logic            err_q;
  logic [7:0]      stack_q [STACK_DEPTH];

  logic            push, pop, taken;
  logic [SPW-1:0]  sp_m1;

  assign sp_m1 = sp_q - SP_ONE;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    load_addr   = 1'b0;
    target_addr = 8'h00;
    push        = 1'b0;
    pop         = 1'b0;
    taken       = 1'b0;
    case (state_q)
      ST_OP: begin
        if (instr_data >= OP_JMP && instr_data <= OP_CALL) begin
          op_d    = instr_data;
          state_d = ST_ARG;
        end else if (instr_data == OP_RET) begin
          // An empty-stack RET still loads, sending the PC to address 00.
          load_addr   = 1'b1;
          pop         = 1'b1;
          target_addr = (count_q != '0) ? stack_q[sp_m1] : 8'h00;
        end else if (other_arg) begin
          op_d    = 8'h00;
          state_d = ST_ARG;
        end
      end
      ST_ARG: begin
        state_d = ST_OP;
        taken = (op_q == OP_JMP) || (op_q == OP_CALL) ||
                ((op_q == OP_JZ)  &&  flag_z) ||
                ((op_q == OP_JNZ) && !flag_z) ||
                ((op_q == OP_JC)  &&  flag_c);
        if (taken) begin
          load_addr   = 1'b1;
          target_addr = instr_data;
        end
        push = (op_q == OP_CALL);
      end
      default: state_d = ST_OP;
    endcase
    if (rst) begin
      load_addr   = 1'b0;
      target_addr = 8'h00;
      push        = 1'b0;
      pop         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OP;
      op_q    <= 8'h00;
      sp_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (push) begin
        sp_q <= sp_q + SP_ONE;
        // When full the write lands on the oldest entry, so depth stays saturated.
        if (count_q == CNT_FULL) err_q <= 1'b1;
        else                     count_q <= count_q + CNT_ONE;
      end else if (pop) begin
        if (count_q == '0) begin
          err_q <= 1'b1;
        end else begin
          sp_q    <= sp_m1;
          count_q <= count_q - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q] <= pc_addr + 8'd1;
  end

  assign in_operand  = (state_q == ST_ARG);
  assign stack_count = count_q;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - directed self-checking bench for branch_unit
module tb_branch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pc_addr = 8'h00;
  logic [7:0] instr_data = 8'h00;
  logic       other_arg = 1'b0;
  logic       flag_z = 1'b0;
  logic       flag_c = 1'b0;
  logic       load_addr;
  logic [7:0] target_addr;
  logic       in_operand;
  logic [2:0] stack_count;
  logic       stack_err;

  int checks = 0;
  int errors = 0;

  branch_unit #(.STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .instr_data(instr_data),
    .other_arg(other_arg), .flag_z(flag_z), .flag_c(flag_c),
    .load_addr(load_addr), .target_addr(target_addr), .in_operand(in_operand),
    .stack_count(stack_count), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte, check the combinational load request, then advance one clock.
  task automatic cyc(input string tag, input logic [7:0] pc, input logic [7:0] d,
                     input logic oa, input logic fz, input logic fc,
                     input logic el, input logic [7:0] et);
    pc_addr = pc; instr_data = d; other_arg = oa; flag_z = fz; flag_c = fc;
    #2;
    check({tag, "_load"}, 32'(load_addr), 32'(el));
    check({tag, "_tgt"}, 32'(target_addr), 32'(et));
    @(posedge clk); #1;
  endtask

  task automatic state(input string tag, input logic eo, input logic [2:0] ec, input logic ee);
    check({tag, "_inop"}, 32'(in_operand), 32'(eo));
    check({tag, "_cnt"}, 32'(stack_count), 32'(ec));
    check({tag, "_err"}, 32'(stack_err), 32'(ee));
  endtask

  initial begin
    // Reset: RET byte must not load while rst is high
    cyc("rst", 8'h00, 8'hF5, 0, 0, 0, 0, 8'h00);
    state("rst", 0, 0, 0);
    rst = 1'b0;

    // JMP
    cyc("jmp_op", 8'h00, 8'hF0, 0, 0, 0, 0, 8'h00);
    check("jmp_inop", 32'(in_operand), 32'd1);
    cyc("jmp_arg", 8'h01, 8'h20, 0, 0, 0, 1, 8'h20);
    check("jmp_after", 32'(in_operand), 32'd0);
    cyc("jmp_next", 8'h20, 8'h00, 0, 0, 0, 0, 8'h00);

    // Conditionals
    cyc("jz_op", 8'h00, 8'hF1, 0, 0, 0, 0, 8'h00);
    cyc("jz_nt", 8'h01, 8'h40, 0, 0, 0, 0, 8'h00);
    cyc("jnz_op", 8'h02, 8'hF2, 0, 0, 0, 0, 8'h00);
    cyc("jnz_t", 8'h03, 8'h40, 0, 0, 0, 1, 8'h40);
    cyc("jz2_op", 8'h40, 8'hF1, 0, 1, 0, 0, 8'h00);
    cyc("jz_t", 8'h41, 8'h55, 0, 1, 0, 1, 8'h55);
    cyc("jnz2_op", 8'h55, 8'hF2, 0, 1, 0, 0, 8'h00);
    cyc("jnz_nt", 8'h56, 8'h99, 0, 1, 0, 0, 8'h00);
    cyc("jc_op", 8'h57, 8'hF3, 0, 0, 1, 0, 8'h00);
    cyc("jc_t", 8'h58, 8'h66, 0, 0, 1, 1, 8'h66);
    cyc("jc2_op", 8'h66, 8'hF3, 0, 0, 0, 0, 8'h00);
    cyc("jc_nt", 8'h67, 8'h77, 0, 0, 0, 0, 8'h00);

    // CALL / RET
    cyc("call_op", 8'h10, 8'hF4, 0, 0, 0, 0, 8'h00);
    cyc("call_arg", 8'h11, 8'h80, 0, 0, 0, 1, 8'h80);
    state("call", 0, 1, 0);
    cyc("ret", 8'h80, 8'hF5, 0, 0, 0, 1, 8'h12);
    state("ret", 0, 0, 0);

    // Operand masking: F5 as data of a non-branch opcode
    cyc("oa_op", 8'h12, 8'h3A, 1, 0, 0, 0, 8'h00);
    check("oa_inop", 32'(in_operand), 32'd1);
    cyc("oa_arg", 8'h13, 8'hF5, 0, 0, 0, 0, 8'h00);
    state("oa", 0, 0, 0);
    cyc("plain", 8'h14, 8'h3B, 0, 0, 0, 0, 8'h00);
    check("plain_inop", 32'(in_operand), 32'd0);

    // Overflow: five nested CALLs into a depth-4 stack
    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("ovf%0d_op", i), 8'(2 * i), 8'hF4, 0, 0, 0, 0, 8'h00);
      cyc($sformatf("ovf%0d_arg", i), 8'(2 * i + 1), 8'(2 * i + 2), 0, 0, 0, 1, 8'(2 * i + 2));
      if (i == 3) state("ovf_full", 0, 4, 0);
    end
    state("ovf", 0, 4, 1);
    // Oldest return (02) was overwritten
    cyc("pop0", 8'h30, 8'hF5, 0, 0, 0, 1, 8'h0A);
    cyc("pop1", 8'h31, 8'hF5, 0, 0, 0, 1, 8'h08);
    cyc("pop2", 8'h32, 8'hF5, 0, 0, 0, 1, 8'h06);
    cyc("pop3", 8'h33, 8'hF5, 0, 0, 0, 1, 8'h04);
    state("pops", 0, 0, 1);
    cyc("undf", 8'h34, 8'hF5, 0, 0, 0, 1, 8'h00);
    state("undf", 0, 0, 1);

    // Underflow from a clean reset sets the sticky error
    rst = 1'b1;
    cyc("rst2", 8'h00, 8'h00, 0, 0, 0, 0, 8'h00);
    state("rst2", 0, 0, 0);
    rst = 1'b0;
    cyc("undf2", 8'h00, 8'hF5, 0, 0, 0, 1, 8'h00);
    state("undf2", 0, 0, 1);

    // Reset during the operand of a JMP
    cyc("rarg_op", 8'h01, 8'hF0, 0, 0, 0, 0, 8'h00);
    check("rarg_inop", 32'(in_operand), 32'd1);
    rst = 1'b1;
    cyc("rarg", 8'h02, 8'h20, 0, 0, 0, 0, 8'h00);
    state("rarg", 0, 0, 0);
    rst = 1'b0;
    cyc("rarg_next", 8'h03, 8'hF5, 0, 0, 0, 1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
